// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, RV32I load/store
// size encodings and the latched request record.
package dmem_responder_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // KIND_BOTH marks a request that raised MemRead and MemWrite together.
  typedef enum logic [1:0] {
    KIND_LOAD,
    KIND_STORE,
    KIND_BOTH
  } dmem_kind_e;

  typedef struct packed {
    dmem_kind_e               kind;
    logic [DMEM_ADDR_W-1:0]   addr;
    logic [DMEM_DATA_W-1:0]   wdata;
    logic [2:0]               func3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for one access: byte enables and replicated store data,
// extended load data, and a flag for misaligned or unsupported func3 values.
module dmem_lane_unit
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [2:0]  func3,
  input  logic        is_store,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        bad
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    sel_byte = rd_word[7:0];
    case (byte_off)
      2'd0: sel_byte = rd_word[7:0];
      2'd1: sel_byte = rd_word[15:8];
      2'd2: sel_byte = rd_word[23:16];
      2'd3: sel_byte = rd_word[31:24];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  // Decode size/signedness into lanes; an illegal access enables no lane and reads as zero.
  always_comb begin
    byte_en = 4'b0000;
    st_data = wr_data;
    ld_data = 32'h0;
    bad     = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        bad     = is_store && (func3 == F3_BU);
        byte_en = 4'b0001 << byte_off;
        st_data = {4{wr_data[7:0]}};
        ld_data = (func3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
      end
      F3_H, F3_HU: begin
        bad     = byte_off[0] || (is_store && (func3 == F3_HU));
        byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wr_data[15:0]}};
        ld_data = (func3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
      end
      F3_W: begin
        bad     = (byte_off != 2'd0);
        byte_en = 4'b1111;
        st_data = wr_data;
        ld_data = rd_word;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      byte_en = 4'b0000;
      ld_data = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency data memory for the MEM stage: accepts one load or store,
// stalls the pipeline with busy, performs the access LATENCY cycles later and
// pulses resp_valid with the extended read data.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DM_ADDRESS = DMEM_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2**(DM_ADDRESS-2),
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  resp_valid,
  output logic                  busy,
  output logic                  err
);

  if (LATENCY < 1) begin : g_latency_check
    $error("dmem_responder: LATENCY must be at least 1");
  end
  if (DATA_W != 32) begin : g_width_check
    $error("dmem_responder: byte lanes assume a 32-bit word");
  end
  if (DM_ADDRESS != DMEM_ADDR_W) begin : g_addr_check
    $error("dmem_responder: request record carries the package address width");
  end

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  dmem_state_e       state;
  logic [CNT_W-1:0]  count;
  dmem_req_t         req_q;
  dmem_req_t         live_req;
  dmem_req_t         cur_req;
  logic              request;
  logic              enter_resp;
  logic              is_store;
  logic              req_err;
  logic              do_write;
  logic [DM_ADDRESS-3:0] cur_word;
  logic [31:0]       rd_word;
  logic [3:0]        byte_en;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic              lane_bad;
  logic [31:0]       mem [DEPTH];

  // With LATENCY==1 the access happens straight out of IDLE, so the live
  // inputs feed the lane unit there; otherwise the latched request does.
  always_comb begin
    request        = MemRead || MemWrite;
    live_req.kind  = (MemRead && MemWrite) ? KIND_BOTH :
                     (MemWrite ? KIND_STORE : KIND_LOAD);
    live_req.addr  = addr;
    live_req.wdata = wr_data;
    live_req.func3 = func3;
    cur_req        = (state == IDLE) ? live_req : req_q;
    enter_resp     = ((state == IDLE) && request && (LATENCY == 1)) ||
                     ((state == WAIT) && (count == CNT_W'(1)));
    is_store       = (cur_req.kind == KIND_STORE);
    req_err        = (cur_req.kind == KIND_BOTH) || lane_bad;
    do_write       = enter_resp && is_store && !req_err && !reset;
    cur_word       = cur_req.addr[DM_ADDRESS-1:2];
    rd_word        = mem[cur_word];
    busy           = ((state == IDLE) && request) || (state == WAIT);
  end

  dmem_lane_unit u_lane (
    .byte_off (cur_req.addr[1:0]),
    .func3    (cur_req.func3),
    .is_store (is_store),
    .wr_data  (cur_req.wdata),
    .rd_word  (rd_word),
    .byte_en  (byte_en),
    .st_data  (st_data),
    .ld_data  (ld_data),
    .bad      (lane_bad)
  );

  // Request FSM and latency counter; response outputs register on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      req_q      <= '0;
      rd_data    <= '0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            req_q <= live_req;
            count <= CNT_W'(LATENCY - 1);
            state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        err        <= req_err;
        if (req_err)        rd_data <= '0;
        else if (!is_store) rd_data <= ld_data;
      end
    end
  end

  // Commit the enabled byte lanes of a legal store; the array is never cleared.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[cur_word][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule
